// File: rtl/bus_pkg.sv
// Shared bus-arbitration definitions: widths, mux source indices, arbiter
// state encoding and a popcount helper.
package bus_pkg;

  localparam int unsigned N_SRC  = 32;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned HOLD_W = 8;

  // Mux select codes of the named bus sources; 24-31 are spare.
  localparam logic [SEL_W-1:0] SRC_R0     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SRC_R1     = SEL_W'(1);
  localparam logic [SEL_W-1:0] SRC_R2     = SEL_W'(2);
  localparam logic [SEL_W-1:0] SRC_R3     = SEL_W'(3);
  localparam logic [SEL_W-1:0] SRC_R4     = SEL_W'(4);
  localparam logic [SEL_W-1:0] SRC_R5     = SEL_W'(5);
  localparam logic [SEL_W-1:0] SRC_R6     = SEL_W'(6);
  localparam logic [SEL_W-1:0] SRC_R7     = SEL_W'(7);
  localparam logic [SEL_W-1:0] SRC_R8     = SEL_W'(8);
  localparam logic [SEL_W-1:0] SRC_R9     = SEL_W'(9);
  localparam logic [SEL_W-1:0] SRC_R10    = SEL_W'(10);
  localparam logic [SEL_W-1:0] SRC_R11    = SEL_W'(11);
  localparam logic [SEL_W-1:0] SRC_R12    = SEL_W'(12);
  localparam logic [SEL_W-1:0] SRC_R13    = SEL_W'(13);
  localparam logic [SEL_W-1:0] SRC_R14    = SEL_W'(14);
  localparam logic [SEL_W-1:0] SRC_R15    = SEL_W'(15);
  localparam logic [SEL_W-1:0] SRC_HI     = SEL_W'(16);
  localparam logic [SEL_W-1:0] SRC_LO     = SEL_W'(17);
  localparam logic [SEL_W-1:0] SRC_ZHI    = SEL_W'(18);
  localparam logic [SEL_W-1:0] SRC_ZLO    = SEL_W'(19);
  localparam logic [SEL_W-1:0] SRC_PC     = SEL_W'(20);
  localparam logic [SEL_W-1:0] SRC_MDR    = SEL_W'(21);
  localparam logic [SEL_W-1:0] SRC_INPORT = SEL_W'(22);
  localparam logic [SEL_W-1:0] SRC_CSIGN  = SEL_W'(23);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Number of set bits in a request vector (0..32).
  function automatic logic [CNT_W-1:0] popcount(input logic [N_SRC-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration interface.
//   req       : per-source request lines (driven by the control sequencer)
//   grant     : one-hot owner grant
//   sel       : binary owner index, feeds the bus mux select
//   bus_valid : grant nonzero, sel meaningful
//   preempt   : pulse during the forced dead cycle
//   waiting   : count of requesters other than the owner
// master = arbiter side, slave = sequencer / mux side.
interface bus_source_arbiter_if;
  import bus_pkg::*;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             bus_valid;
  logic             preempt;
  logic [CNT_W-1:0] waiting;

  modport master (
    input  req,
    output grant, sel, bus_valid, preempt, waiting
  );

  modport slave (
    output req,
    input  grant, sel, bus_valid, preempt, waiting
  );

endinterface

// File: rtl/bus_source_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest-offset requester starting at
// ptr_i and searching upward with wrap.
//   req_i : request vector
//   ptr_i : search start index
//   any_o : at least one request present
//   win_o : winning index (0 when any_o is low)
module rr_pick
  import bus_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             any_o,
  output logic [SEL_W-1:0] win_o
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_i[ptr_i + SEL_W'(i)]) begin
        any_o = 1'b1;
        win_o = ptr_i + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Bus source arbiter: turns 32 source requests into a registered one-hot
// grant plus binary mux select, round-robin among simultaneous requesters,
// with a bounded hold time and a one-cycle dead gap on preemption.
//   clock    : rising-edge clock
//   clear_n  : synchronous active-low clear
//   bus      : arbitration interface (master side), see bus_source_arbiter_if
// MAX_HOLD   : cycles an owner may keep the bus while others wait (1..255)
module bus_source_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clock,
  input  logic                 clear_n,
  bus_source_arbiter_if.master bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              preempt_q, preempt_d;
  logic [CNT_W-1:0]  waiting_q, waiting_d;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_win;
  logic              owner_req;
  logic              others;
  logic              arb_en;

  rr_pick u_rr_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .win_o (pick_win)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = '0;
    sel_d     = sel_q;
    valid_d   = 1'b0;
    preempt_d = 1'b0;
    arb_en    = 1'b0;

    owner_req = bus.req[sel_q];
    others    = |(bus.req & ~grant_q);

    case (state_q)
      IDLE, GAP: arb_en = 1'b1;
      OWN: begin
        if (!owner_req) begin
          // Release wins over a coincident timeout: zero-bubble handoff.
          arb_en = 1'b1;
        end else if (others && (hold_q >= HOLD_LIM)) begin
          state_d   = GAP;
          preempt_d = 1'b1;
          hold_d    = '0;
        end else begin
          grant_d = grant_q;
          valid_d = 1'b1;
          if (others && (hold_q != '1)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // In OWN the owner bit is already low here, so it cannot re-win.
    if (arb_en) begin
      if (pick_any) begin
        state_d = OWN;
        grant_d = N_SRC'(1) << pick_win;
        sel_d   = pick_win;
        valid_d = 1'b1;
        ptr_d   = pick_win + SEL_W'(1);
        hold_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end

    // Counted against the grant being registered this edge.
    waiting_d = popcount(bus.req & ~grant_d);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      waiting_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      waiting_q <= waiting_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.bus_valid = valid_q;
  assign bus.preempt   = preempt_q;
  assign bus.waiting   = waiting_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter: vector table for grant/handoff/wrap
// behaviour, plus hand sequences for preemption, release-at-timeout and clear.
module tb_bus_source_arbiter;

  logic clk;
  logic clear_n;
  int   checks;
  int   failures;

  bus_source_arbiter_if bus();

  bus_source_arbiter #(.MAX_HOLD(15)) dut (
    .clock   (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr_n;
    logic [31:0] req;
    logic [31:0] grant;
    logic [4:0]  sel;
    logic        valid;
    logic        preempt;
    logic [5:0]  waiting;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] eg, input logic [4:0] es,
                       input logic ev, input logic ep, input logic [5:0] ew);
    checks++;
    if (bus.grant !== eg || bus.sel !== es || bus.bus_valid !== ev ||
        bus.preempt !== ep || bus.waiting !== ew) begin
      failures++;
      $display("FAIL %s: got grant=%h sel=%0d valid=%b preempt=%b waiting=%0d, want grant=%h sel=%0d valid=%b preempt=%b waiting=%0d",
               name, bus.grant, bus.sel, bus.bus_valid, bus.preempt, bus.waiting,
               eg, es, ev, ep, ew);
    end
  endtask

  // Structural invariants on every cycle.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(bus.grant) || (bus.bus_valid != (|bus.grant)) ||
        (bus.preempt && bus.bus_valid)) begin
      failures++;
      $display("FAIL invariant: got grant=%h valid=%b preempt=%b, want one-hot-or-zero grant, valid==|grant, no preempt while valid",
               bus.grant, bus.bus_valid, bus.preempt);
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    clear_n  = 1'b0;
    bus.req  = '0;

    //          clr_n  req           grant         sel    v     p     wait
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'h0000_0004, 5'd2,  1'b1, 1'b0, 6'd0};
    vecs[2]  = '{1'b1, 32'h0010_0000, 32'h0010_0000, 5'd20, 1'b1, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd20, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 6'd0};
    vecs[5]  = '{1'b1, 32'h8000_0001, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 6'd1};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 6'd0};
    vecs[7]  = '{1'b1, 32'h0000_0001, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 6'd0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 6'd0};
    vecs[9]  = '{1'b1, 32'h0000_0007, 32'h0000_0002, 5'd1,  1'b1, 1'b0, 6'd2};
    vecs[10] = '{1'b1, 32'h0000_0007, 32'h0000_0002, 5'd1,  1'b1, 1'b0, 6'd2};
    vecs[11] = '{1'b1, 32'h0000_0005, 32'h0000_0004, 5'd2,  1'b1, 1'b0, 6'd1};
    vecs[12] = '{1'b1, 32'h0000_0001, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 6'd0};
    vecs[13] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 6'd0};

    step();
    step();

    for (int i = 0; i < 14; i++) begin
      clear_n = vecs[i].clr_n;
      bus.req = vecs[i].req;
      step();
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid,
            vecs[i].preempt, vecs[i].waiting);
    end

    // Preemption: R5 holds while MDR waits from the first cycle.
    clear_n = 1'b0;
    bus.req = '0;
    step();
    clear_n = 1'b1;
    bus.req = 32'h0020_0020;
    step();
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("r5_own_c%0d", k), 32'h0000_0020, 5'd5, 1'b1, 1'b0, 6'd1);
      step();
    end
    check("preempt_gap", 32'h0000_0000, 5'd5, 1'b0, 1'b1, 6'd2);
    step();
    check("mdr_after_gap", 32'h0020_0000, 5'd21, 1'b1, 1'b0, 6'd1);

    // MDR drops its request on the timeout cycle: direct handoff to R5.
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("mdr_own_c%0d", k), 32'h0020_0000, 5'd21, 1'b1, 1'b0, 6'd1);
      if (k == 15) bus.req = 32'h0000_0020;
      step();
    end
    check("release_at_timeout", 32'h0000_0020, 5'd5, 1'b1, 1'b0, 6'd0);

    // Clear while HI owns with three waiters.
    bus.req = '0;
    step();
    check("release_to_idle", 32'h0000_0000, 5'd5, 1'b0, 1'b0, 6'd0);
    bus.req = 32'h0001_0007;
    step();
    check("owner_hi", 32'h0001_0000, 5'd16, 1'b1, 1'b0, 6'd3);
    clear_n = 1'b0;
    step();
    check("clear_mid_own", 32'h0000_0000, 5'd0, 1'b0, 1'b0, 6'd0);
    clear_n = 1'b1;
    bus.req = 32'h0001_0001;
    step();
    check("after_clear_ptr0", 32'h0000_0001, 5'd0, 1'b1, 1'b0, 6'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_source_arbiter.md
# bus_source_arbiter

Drives the 5-bit select of the 32-source datapath bus multiplexer from per-source "out" requests raised by the control unit. It encodes 32 request lines into one registered one-hot grant and a binary select, and arbitrates round-robin when several sources request at once. It bounds how long one source may own the bus and forces a one-cycle dead-bus gap on preemption, so the bus never switches drivers mid-transfer without notice. It sits between the control sequencer and the bus mux select input.

## Interface
- N_SRC, 32, number of bus sources (fixed to 32 in this design).
- SEL_W, 5, select width, equal to log2(N_SRC).
- MAX_HOLD, 15, maximum consecutive cycles one owner keeps the bus while another source waits. Range 1..255.
- clock  in  1  single clock. All logic is on its rising edge.
- clear_n  in  1  reset. Synchronous, active-low.
- req  in  32  request lines, one per source. Bit index equals the mux select code: 0-15 R0-R15, 16 HI, 17 LO, 18 Z_HI, 19 Z_LO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended, 24-31 spare.
- grant  out  32  registered one-hot grant. Always zero or exactly one bit set.
- sel  out  5  registered binary index of the current owner. It feeds the mux select directly.
- bus_valid  out  1  high when grant is nonzero and sel is meaningful.
- preempt  out  1  one-cycle pulse when the owner is forcibly removed.
- waiting  out  6  registered popcount of requests excluding the owner. Range 0..32.

## Operation
- State machine with three states:
  - IDLE: no owner.
  - OWN: grant[sel] is set.
  - GAP: forced dead cycle after a preemption.
- Priority pointer ptr (5 bits): the round-robin search starts at ptr and proceeds upward, wrapping 31→0.
- IDLE:
  - If req is nonzero, pick the winner w starting at ptr. Next cycle: grant=1<<w, sel=w, bus_valid=1, state OWN, ptr=w+1 mod 32, hold_cnt=0.
  - If req is zero, stay in IDLE.
- OWN, owner drops its request (req[sel]=0):
  - Re-arbitrate in the same cycle among the remaining requests, with zero bubble. The new owner is valid on the next edge.
  - If no requests remain, go to IDLE with grant=0 and bus_valid=0.
- OWN, owner holds its request:
  - With no other request: hold_cnt saturates and there is no preemption.
  - With any other request: hold_cnt increments each cycle.
  - When hold_cnt reaches MAX_HOLD-1 while others are still waiting: next cycle grant=0, bus_valid=0, preempt=1, state GAP.
- GAP: lasts exactly one cycle. Next cycle arbitrate as in IDLE. The pointer has already advanced past the preempted source, so the preempted source is excluded from winning unless it is the only requester.
- sel holds its last value whenever bus_valid=0. Consumers ignore sel while bus_valid=0.
- waiting = popcount(req & ~grant), registered each cycle.
- Spare sources 24-31 arbitrate like all other sources. No masking is applied.

## Timing
- Reset value of every output is 0: grant, sel, bus_valid, preempt, waiting.
- Reset value of every internal register is 0: ptr=0, hold_cnt=0, state=IDLE.
- Latency from request to grant is 1 cycle.
- Handoff on release is 0 bubble cycles. Handoff on preemption is exactly 1 dead cycle (GAP).
- preempt is high for exactly the GAP cycle.
- A release arriving on the same cycle as the timeout takes priority: a normal handoff occurs with no GAP and no preempt.
- When clear_n is low mid-ownership, all outputs are 0 on the next edge regardless of req. Arbitration restarts from ptr=0.
- A request asserted and removed within one cycle while another source owns the bus is never granted. Requesters hold req until they see their grant.

## Structure
- Shared package bus_pkg contains:
  - the SEL_W constant;
  - named source-index constants SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN;
  - the state enum arb_state_t {IDLE, OWN, GAP}.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are any and the 5-bit winner. It is reused by later bus-arbitration blocks.

## Test plan
- Reset, then req=32'h0000_0004 → one cycle later grant=32'h4, sel=2, bus_valid=1, waiting=0.
- Owner R2 drops its request; req=32'h0010_0000 (PC) in the same cycle → next cycle sel=20, with bus_valid never low.
- req=32'h8000_0001 from IDLE with ptr=0 → sel=0. Then drop bit 0 → sel=31. Drop bit 31, assert bit 0 again → sel=0, exercising the wrap.
- MAX_HOLD=15, owner R5 holds while MDR waits → bus_valid low and preempt=1 on cycle 16 of ownership. MDR (sel=21) is granted the following cycle.
- Release coincident with the timeout → direct handoff, preempt stays 0.
- clear_n=0 while owner is HI (sel=16) with waiting=3 → next cycle all outputs 0. After release of reset, req=32'h0001_0001 → sel=0.
